// File: rtl/dac8_seq_pkg.sv
// Shared types and constants for the EF_DAC8 sample sequencer.
package dac8_seq_pkg;

  localparam int unsigned DAC8_W = 8;

  // Midscale code: the DAC output sits at the centre of its range while idle.
  localparam logic [DAC8_W-1:0] IDLE_CODE_DEF = 8'h80;

  typedef enum logic {
    SEQ_IDLE,
    SEQ_RUN
  } seq_state_e;

endpackage

// File: rtl/dac8_sample_fifo.sv
// Synchronous sample FIFO with push, pop and flush, plus full/empty and an occupancy count.
module dac8_sample_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_level;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_level == (PTR_W + 1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (PTR_W + 1)'(1);
        2'b01:   r_level <= r_level - (PTR_W + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone defines which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/dac8_sample_sequencer.sv
// Paces buffered 8-bit samples onto the EF_DAC8 VALUE input at div+1 cycles per sample.
// Optional DAC8_SEQ_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module dac8_sample_sequencer
  import dac8_seq_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter int unsigned       DIV_W      = 16,
  parameter logic [DAC8_W-1:0] IDLE_CODE  = IDLE_CODE_DEF
) (
  input  logic                         UserCLK,
  input  logic                         RST,
  input  logic                         enable,
  input  logic [DIV_W-1:0]             div,
  input  logic [DAC8_W-1:0]            s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [DAC8_W-1:0]            VALUE,
  output logic                         sample_strobe,
  output logic                         underrun,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
`ifdef DAC8_SEQ_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                  underrun_cnt
`endif
);

  seq_state_e        r_state;
  logic [DIV_W-1:0]  r_cnt;
  logic [DAC8_W-1:0] r_value;
  logic              r_strobe;
  logic              r_underrun;

  logic              w_full;
  logic              w_empty;
  logic [DAC8_W-1:0] w_head;
  logic              w_tick;
  logic              w_flush;
  logic              w_push;
  logic              w_pop;

  // A counter already past a freshly lowered div ticks at once instead of wrapping.
  assign w_tick  = (r_state == SEQ_RUN) && enable && (r_cnt >= div);
  assign w_flush = (r_state == SEQ_RUN) && !enable;
  assign w_push  = s_valid & s_ready;
  assign w_pop   = w_tick & ~w_empty;

  assign s_ready       = ~w_full;
  assign VALUE         = r_value;
  assign sample_strobe = r_strobe;
  assign underrun      = r_underrun;

  dac8_sample_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DAC8_W)
  ) u_fifo (
    .i_clk   (UserCLK),
    .i_rst   (RST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata (s_data),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      r_state    <= SEQ_IDLE;
      r_cnt      <= '0;
      r_value    <= IDLE_CODE;
      r_strobe   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_strobe   <= 1'b0;
      r_underrun <= 1'b0;
      unique case (r_state)
        SEQ_IDLE: begin
          if (enable) begin
            r_state <= SEQ_RUN;
            r_cnt   <= '0;
          end
        end
        SEQ_RUN: begin
          if (!enable) begin
            r_state <= SEQ_IDLE;
            r_value <= IDLE_CODE;
          end else if (w_tick) begin
            r_cnt <= '0;
            if (!w_empty) begin
              r_value  <= w_head;
              r_strobe <= 1'b1;
            end else begin
              r_underrun <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end
        end
        default: r_state <= SEQ_IDLE;
      endcase
    end
  end

`ifdef DAC8_SEQ_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_cnt;

  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      r_underrun_cnt <= '0;
    end else if (w_flush) begin
      r_underrun_cnt <= '0;
    end else if (w_tick && w_empty && (r_underrun_cnt != 16'hFFFF)) begin
      r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign underrun_cnt = r_underrun_cnt;
`endif

endmodule

// File: tb/tb_dac8_sample_sequencer.sv
// Bench for dac8_sample_sequencer: directed scenarios plus random traffic against a queue model.
module tb_dac8_sample_sequencer;

  localparam int DEPTH = 4;
  localparam int DIV_W = 16;

  logic             UserCLK = 1'b0;
  logic             RST;
  logic             enable;
  logic [DIV_W-1:0] div;
  logic [7:0]       s_data;
  logic             s_valid;
  logic             s_ready;
  logic [7:0]       VALUE;
  logic             sample_strobe;
  logic             underrun;
  logic [2:0]       fifo_level;
`ifdef DAC8_SEQ_UNDERRUN_CNT_EN
  logic [15:0]      underrun_cnt;
`endif

  always #5 UserCLK = ~UserCLK;

  dac8_sample_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .DIV_W      (DIV_W),
    .IDLE_CODE  (8'h80)
  ) dut (
    .UserCLK       (UserCLK),
    .RST           (RST),
    .enable        (enable),
    .div           (div),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .VALUE         (VALUE),
    .sample_strobe (sample_strobe),
    .underrun      (underrun),
    .fifo_level    (fifo_level)
`ifdef DAC8_SEQ_UNDERRUN_CNT_EN
    ,
    .underrun_cnt  (underrun_cnt)
`endif
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: queue of pending samples plus cycles elapsed in the current period.
  bit         m_run;
  logic [7:0] m_q[$];
  int         m_elapsed;
  logic [7:0] m_value;
  bit         m_strobe;
  bit         m_under;
  int         m_ucnt;

  function automatic void model_reset();
    m_run     = 0;
    m_q.delete();
    m_elapsed = 0;
    m_value   = 8'h80;
    m_strobe  = 0;
    m_under   = 0;
    m_ucnt    = 0;
  endfunction

  function automatic void model_edge();
    bit accept;
    accept   = s_valid && (m_q.size() < DEPTH);
    m_strobe = 0;
    m_under  = 0;
    if (!m_run) begin
      if (enable) begin
        m_run     = 1;
        m_elapsed = 0;
      end
      if (accept) m_q.push_back(s_data);
    end else if (!enable) begin
      m_run   = 0;
      m_q.delete();
      m_value = 8'h80;
      m_ucnt  = 0;
    end else begin
      if (m_elapsed >= int'(div)) begin
        m_elapsed = 0;
        if (m_q.size() > 0) begin
          m_value  = m_q.pop_front();
          m_strobe = 1;
        end else begin
          m_under = 1;
          if (m_ucnt < 65535) m_ucnt++;
        end
      end else begin
        m_elapsed++;
      end
      if (accept) m_q.push_back(s_data);
    end
  endfunction

  task automatic compare_all();
    check("value", VALUE, m_value);
    check("strobe", sample_strobe, m_strobe);
    check("underrun", underrun, m_under);
    check("level", fifo_level, m_q.size());
    check("ready", s_ready, (m_q.size() < DEPTH));
`ifdef DAC8_SEQ_UNDERRUN_CNT_EN
    check("ucnt", underrun_cnt, m_ucnt);
`endif
  endtask

  task automatic step();
    @(posedge UserCLK);
    if (!RST) model_edge();
    #1;
    compare_all();
  endtask

  int strobe_at[$];
  int under_at[$];

  initial begin
    RST     = 1'b1;
    enable  = 1'b0;
    div     = '0;
    s_valid = 1'b0;
    s_data  = '0;
    model_reset();
    repeat (2) @(posedge UserCLK);
    #1;
    compare_all();
    RST = 1'b0;

    // Asynchronous reset mid-RUN with three samples queued.
    div    = 16'd100;
    enable = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 8'h51 + 8'(i);
      step();
    end
    s_valid = 1'b0;
    step();
    check("pre_rst_level", fifo_level, 3);
    #2;
    RST = 1'b1;
    #1;
    check("rst_value", VALUE, 8'h80);
    check("rst_level", fifo_level, 0);
    check("rst_ready", s_ready, 1);
    check("rst_strobe", sample_strobe, 0);
    model_reset();
    enable = 1'b0;
    @(posedge UserCLK);
    #1;
    RST = 1'b0;
    step();

    // div=3: samples land 4, 8, 12 edges after enable, then periodic underruns.
    div    = 16'd3;
    enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k < 3) begin
        s_valid = 1'b1;
        s_data  = 8'h10 * 8'(k + 1);
      end else begin
        s_valid = 1'b0;
      end
      step();
      if (sample_strobe) strobe_at.push_back(k);
      if (underrun) under_at.push_back(k);
    end
    check("n_strobes", strobe_at.size(), 3);
    if (strobe_at.size() == 3) begin
      check("strobe0", strobe_at[0], 4);
      check("strobe1", strobe_at[1], 8);
      check("strobe2", strobe_at[2], 12);
    end
    check("n_underruns", under_at.size(), 1);
    if (under_at.size() == 1) check("under0", under_at[0], 16);
    check("hold_value", VALUE, 8'h30);

    // Fill with enable=0, div=0: a fifth offer is refused.
    enable = 1'b0;
    div    = '0;
    step();
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 8'hA0 + 8'(i);
      step();
    end
    s_valid = 1'b0;
    check("full_ready", s_ready, 0);
    check("full_level", fifo_level, 4);

    // Enable with div=0: one pop per cycle in order.
    enable = 1'b1;
    step();
    check("drain_level_start", fifo_level, 4);
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain_value", VALUE, 8'hA0 + 8'(i));
      check("drain_level", fifo_level, 3 - i);
    end

    // Disable with two samples queued while a push is offered.
    enable = 1'b0;
    step();
    div    = 16'd50;
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data  = 8'hC0 + 8'(i);
      step();
    end
    check("pre_flush_level", fifo_level, 2);
    enable  = 1'b0;
    s_data  = 8'hEE;
    step();
    s_valid = 1'b0;
    check("flush_value", VALUE, 8'h80);
    check("flush_level", fifo_level, 0);

    // div lowered from 100 to 10 while the counter sits at 50.
    div    = 16'd100;
    enable = 1'b1;
    step();
    repeat (50) step();
    div = 16'd10;
    step();
    check("div_change_tick", underrun, 1);
    under_at.delete();
    for (int k = 0; k < 22; k++) begin
      step();
      if (underrun) under_at.push_back(k);
    end
    check("n_period_ticks", under_at.size(), 2);
    if (under_at.size() == 2) begin
      check("period_tick0", under_at[0], 10);
      check("period_tick1", under_at[1], 21);
    end
`ifdef DAC8_SEQ_UNDERRUN_CNT_EN
    check("ucnt_three", underrun_cnt, 3);
`endif
    enable = 1'b0;
    step();
`ifdef DAC8_SEQ_UNDERRUN_CNT_EN
    check("ucnt_cleared", underrun_cnt, 0);
`endif

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      enable  = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 15) == 0) div = DIV_W'($urandom_range(0, 5));
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
